alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the execute-stage 32-bit ALU. It keeps the eight base operations and their encodings and adds ADC plus iterative SHL/SHR/SAR. Flags are computed at width `WIDTH` and merged into the incoming EFLAGS image, so unaffected bits are preserved. The block sits in the execute stage between operand read and writeback, with a registered output and valid/ready on both sides.

## Interface
- `WIDTH`, default 32: operand and result width; legal values are 8, 16 and 32.
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state immediately.
- `in_valid`, input, 1: an operation is presented.
- `in_ready`, output, 1: the block accepts the presented operation this cycle.
- `op`, input, 4: operation code.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B; `b[4:0]` is the shift count.
- `flags_in`, input, 32: current EFLAGS image.
- `out_valid`, output, 1: result and flags are valid.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `result`, output, WIDTH: registered result.
- `flags_out`, output, 32: registered EFLAGS image.
- `busy`, output, 1: a shift is iterating.

## Operation
- **Op codes:** 0 ADD, 1 OR, 2 NOT, 3 DAA, 4 AND, 5 CLD, 6 CMP, 7 STD, 8 ADC, 9 SHL, 10 SHR, 11 SAR, 12–15 reserved.
- **Flag positions:** CF = bit 0, PF = 2, AF = 4, ZF = 6, SF = 7, DF = 10, OF = 11. Every bit an op does not write is copied from `flags_in`. DF is always copied except for CLD (0) and STD (1).
- **Common flag rules:**
  - SF = `result[WIDTH-1]`.
  - ZF = 1 when all WIDTH bits of `result` are 0.
  - PF = 1 when `result[7:0]` has an even number of ones.
  - AF = carry/borrow out of bit 3.
- **ADD / ADC:**
  - ADD: `result = a + b`. ADC: `result = a + b + flags_in[0]`.
  - CF = carry out of bit WIDTH-1.
  - OF = 1 when `a` and `b` have the same sign and `result` has a different sign.
- **CMP:**
  - `result = a - b`; the result is output but is never written back (the decode stage ignores it).
  - CF = borrow out of bit WIDTH-1.
  - OF = 1 when `a` and `b` have different signs and `result` sign differs from `a`.
- **OR / AND:** OF = CF = AF = 0; SF, ZF, PF per common rules.
- **NOT:** `result = ~a`; `flags_out = flags_in`.
- **DAA:** operates on `a[7:0]`; `result[WIDTH-1:8] = 0`.
  - L = `a[3:0]`. If L > 9: L = (L + 6) mod 16 and c0 = 1.
  - H = `a[7:4]` + c0. If H > 9: H = (H + 6) mod 16 and c1 = 1.
  - CF = AF = c0 | c1.
  - ZF and PF from `result[7:0]`; SF = OF = 0.
- **CLD / STD:** `result = 0`; only DF changes.
- **Shifts:**
  - n = `b[4:0]`; one bit is shifted per cycle.
  - CF = the last bit shifted out.
  - OF is defined only for n = 1: SHL gives `result` MSB ^ CF, SHR gives original `a` MSB, SAR gives 0. For n > 1, OF = 0.
  - AF = 0; SF, ZF, PF per common rules.
  - n = 0: `result = a`, `flags_out = flags_in`, single-cycle path.
  - n ≥ WIDTH is legal; it iterates n times. SHL/SHR then give 0; SAR gives all sign bits.
- **Reserved ops (12–15):** `result = 0`, `flags_out = flags_in`.
- **State machine:**
  - States are IDLE and SHIFT.
  - IDLE → SHIFT on acceptance of a shift with n ≥ 1. The operand is latched into a work register and the counter is loaded with n.
  - SHIFT decrements the counter once per cycle.
  - On the cycle after the counter reaches 0, SHIFT loads the output register and returns to IDLE. If the output register is still full and not draining, SHIFT holds until it is.

## Timing
- **Reset:** `out_valid` = 0, `result` = 0, `flags_out` = 0, `busy` = 0, state = IDLE. Inputs are ignored while `reset` is low.
- **Handshake:**
  - `in_ready = (state == IDLE) && (!out_valid || out_ready)`.
  - Acceptance = `in_valid && in_ready` at an edge E.
- **Latency:**
  - Single-cycle ops and n = 0 shifts: `out_valid` rises at E+1.
  - Shift with n ≥ 1: `busy` is high from E+1 through E+n; `out_valid` rises at E+n+1 (no backpressure).
- **Output hold:** `result` and `flags_out` are stable while `out_valid && !out_ready`.
- **Drain:** `out_valid` clears at the edge where `out_ready` is high and no new result loads.
- **Simultaneous events:** drain and new acceptance in the same cycle are allowed; the output register reloads with no bubble.
- **Reset mid-operation:** aborts the shift. No result is produced after `reset` is released.

## Test plan
- **ADD (WIDTH=32):** a=0x7FFFFFFF, b=1 → at E+1, `result`=0x80000000; OF=1, SF=1, ZF=0, AF=1, PF=1, CF=0.
- **CMP (WIDTH=32):** a=1, b=2 → `result`=0xFFFFFFFF; CF=1, SF=1, AF=1, PF=1, ZF=0, OF=0.
- **DAA:** a=0x9A → `result`=0x00; CF=1, AF=1, ZF=1, PF=1. Then a=0x45 → 0x45 with CF=0.
- **SHL:** a=0x20000001, b=3 → `busy` high for 3 cycles; at E+4, `result`=0x00000008, CF=1, OF=0, `in_ready`=0 meanwhile. Also b=0 → `result`=a and `flags_out`=`flags_in` at E+1.
- **Backpressure:** hold `out_ready`=0 after an ADD → `in_ready`=0 and `result` stable for 5 cycles. Raise `out_ready` with `in_valid` high → drain and new accept at the same edge; next result appears at the following edge.
- **Flag preservation and reset:**
  - STD with `flags_in`=0 → `flags_out`=0x00000400.
  - NOT with `flags_in`=0x000008C5 → `flags_out`=0x000008C5.
  - WIDTH=8 ADC, a=0xFF, b=0x00, CF_in=1 → `result`=0x00, CF=1, ZF=1.
  - Pull `reset` low at cycle 5 of an SHR with n=20 → `out_valid`=0 immediately and no output after release.

Source files
------------

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : Operand/result handshake bundle for the sequential execute ALU.
// Revision : 1.0
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [31:0]      flags_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [31:0]      flags_out;
    logic             busy;

    modport master (
        output in_valid, op, a, b, flags_in, out_ready,
        input  in_ready, out_valid, result, flags_out, busy
    );

    modport slave (
        input  in_valid, op, a, b, flags_in, out_ready,
        output in_ready, out_valid, result, flags_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked execute-stage ALU with EFLAGS merge and iterative shifts.
// Revision : 1.0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);
    localparam int         c_msb    = WIDTH - 1;
    localparam logic [3:0] c_op_add = 4'd0, c_op_or  = 4'd1, c_op_not = 4'd2, c_op_daa = 4'd3;
    localparam logic [3:0] c_op_and = 4'd4, c_op_cld = 4'd5, c_op_cmp = 4'd6, c_op_std = 4'd7;
    localparam logic [3:0] c_op_adc = 4'd8, c_op_shl = 4'd9, c_op_shr = 4'd10, c_op_sar = 4'd11;

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work, r_result;
    logic [4:0]       r_cnt;
    logic [1:0]       r_sop;
    logic [31:0]      r_fsave, r_flags;
    logic             r_one, r_amsb, r_out_valid;

    logic             w_in_ready, w_accept, w_start, w_load, w_fin, w_cin;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_axs, w_axd, w_res, w_step;
    logic [31:0]      w_fl, w_sfl;
    logic             w_step_cf, w_c0, w_c1;
    logic [3:0]       w_lo, w_hi_adj;
    logic [4:0]       w_hi;

    function automatic logic [31:0] szp(input logic [31:0] fl, input logic [WIDTH-1:0] r);
        szp    = fl;
        szp[7] = r[c_msb];
        szp[6] = ~|r;
        szp[2] = ~^r[7:0];
    endfunction

    assign w_cin  = (bus.op == c_op_adc) & bus.flags_in[0];
    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_axs  = bus.a ^ bus.b ^ w_sum[c_msb:0];
    assign w_axd  = bus.a ^ bus.b ^ w_diff[c_msb:0];

    always_comb begin
        w_c0     = (bus.a[3:0] > 4'd9);
        w_lo     = w_c0 ? bus.a[3:0] + 4'd6 : bus.a[3:0];
        w_hi     = {1'b0, bus.a[7:4]} + {4'd0, w_c0};
        w_c1     = (w_hi > 5'd9);
        w_hi_adj = w_c1 ? w_hi[3:0] + 4'd6 : w_hi[3:0];
    end

    // Single-cycle datapath; shifts only take this path when the count is zero.
    always_comb begin
        w_res = '0;
        w_fl  = bus.flags_in;
        case (bus.op)
            c_op_add, c_op_adc: begin
                w_res     = w_sum[c_msb:0];
                w_fl      = szp(bus.flags_in, w_sum[c_msb:0]);
                w_fl[0]   = w_sum[WIDTH];
                w_fl[4]   = w_axs[4];
                w_fl[11]  = (bus.a[c_msb] == bus.b[c_msb]) && (w_sum[c_msb] != bus.a[c_msb]);
            end
            c_op_cmp: begin
                w_res     = w_diff[c_msb:0];
                w_fl      = szp(bus.flags_in, w_diff[c_msb:0]);
                w_fl[0]   = w_diff[WIDTH];
                w_fl[4]   = w_axd[4];
                w_fl[11]  = (bus.a[c_msb] != bus.b[c_msb]) && (w_diff[c_msb] != bus.a[c_msb]);
            end
            c_op_or, c_op_and: begin
                w_res     = (bus.op == c_op_or) ? (bus.a | bus.b) : (bus.a & bus.b);
                w_fl      = szp(bus.flags_in, w_res);
                w_fl[0]   = 1'b0;
                w_fl[4]   = 1'b0;
                w_fl[11]  = 1'b0;
            end
            c_op_not: w_res = ~bus.a;
            c_op_daa: begin
                w_res[7:0] = {w_hi_adj, w_lo};
                w_fl[0]    = w_c0 | w_c1;
                w_fl[4]    = w_c0 | w_c1;
                w_fl[6]    = ~|{w_hi_adj, w_lo};
                w_fl[2]    = ~^{w_hi_adj, w_lo};
                w_fl[7]    = 1'b0;
                w_fl[11]   = 1'b0;
            end
            c_op_cld: w_fl[10] = 1'b0;
            c_op_std: w_fl[10] = 1'b1;
            c_op_shl, c_op_shr, c_op_sar: w_res = bus.a;
            default: ;
        endcase
    end

    // One-bit shift step; r_sop holds op[1:0]: 1 SHL, 2 SHR, 3 SAR.
    always_comb begin
        w_step    = {r_work[c_msb-1:0], 1'b0};
        w_step_cf = r_work[c_msb];
        if (r_sop != 2'd1) begin
            w_step    = {(r_sop == 2'd3) & r_work[c_msb], r_work[c_msb:1]};
            w_step_cf = r_work[0];
        end
        w_sfl     = szp(r_fsave, w_step);
        w_sfl[0]  = w_step_cf;
        w_sfl[4]  = 1'b0;
        w_sfl[11] = 1'b0;
        if (r_one) begin
            case (r_sop)
                2'd1:    w_sfl[11] = w_step[c_msb] ^ w_step_cf;
                2'd2:    w_sfl[11] = r_amsb;
                default: w_sfl[11] = 1'b0;
            endcase
        end
    end

    assign w_in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_start    = w_accept && (bus.op inside {c_op_shl, c_op_shr, c_op_sar}) && (bus.b[4:0] != 5'd0);
    assign w_load     = w_accept && !w_start;
    assign w_fin      = (r_state == SHIFT) && (r_cnt == 5'd1) && (!r_out_valid || bus.out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_sop       <= '0;
            r_fsave     <= '0;
            r_one       <= 1'b0;
            r_amsb      <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_state <= SHIFT;
                    r_work  <= bus.a;
                    r_cnt   <= bus.b[4:0];
                    r_sop   <= bus.op[1:0];
                    r_fsave <= bus.flags_in;
                    r_one   <= (bus.b[4:0] == 5'd1);
                    r_amsb  <= bus.a[c_msb];
                end
                SHIFT: begin
                    // The last step goes straight to the output register, so hold at count 1.
                    if (r_cnt != 5'd1) begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt - 5'd1;
                    end else if (w_fin) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_load) begin
                r_result    <= w_res;
                r_flags     <= w_fl;
                r_out_valid <= 1'b1;
            end else if (w_fin) begin
                r_result    <= w_step;
                r_flags     <= w_sfl;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags_out = r_flags;
    assign bus.busy      = (r_state == SHIFT);
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq at WIDTH 32 and 8.
// Revision : 1.0
// ============================================================================
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] q32[$];
    logic [63:0] q8[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus32 ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour written from the operation rules with plain integer arithmetic.
    function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] fin,
                                  output logic [31:0] res, output logic [31:0] fo);
        longint unsigned mask, ua, ub, t;
        longint sa, sb, st, smax, smin;
        int n, lo, hi, cin;
        bit c0, c1, szp;
        mask = (64'd1 << w) - 1;
        ua = a & mask;
        ub = b & mask;
        smax = (64'sd1 <<< (w - 1)) - 1;
        smin = -(64'sd1 <<< (w - 1));
        sa = (ua > smax) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb = (ub > smax) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        fo = fin;
        res = 0;
        szp = 0;
        case (op)
            4'd0, 4'd8: begin
                cin = (op == 4'd8) ? int'(fin[0]) : 0;
                t = ua + ub + cin;
                res = 32'(t & mask);
                st = sa + sb + cin;
                fo[0] = (t > mask);
                fo[4] = ((ua % 16) + (ub % 16) + cin) > 15;
                fo[11] = (st > smax) || (st < smin);
                szp = 1;
            end
            4'd6: begin
                res = 32'((ua - ub) & mask);
                st = sa - sb;
                fo[0] = (ua < ub);
                fo[4] = (ua % 16) < (ub % 16);
                fo[11] = (st > smax) || (st < smin);
                szp = 1;
            end
            4'd1, 4'd4: begin
                res = 32'((op == 4'd1) ? (ua | ub) : (ua & ub));
                fo[0] = 0; fo[4] = 0; fo[11] = 0;
                szp = 1;
            end
            4'd2: res = 32'(~ua & mask);
            4'd3: begin
                lo = int'(ua % 16);
                hi = int'((ua / 16) % 16);
                c0 = (lo > 9);
                if (c0) lo = (lo + 6) % 16;
                hi = hi + int'(c0);
                c1 = (hi > 9);
                if (c1) hi = (hi + 6) % 16;
                res = 32'(hi * 16 + lo);
                fo[0] = c0 | c1; fo[4] = c0 | c1;
                fo[6] = (res == 0); fo[2] = ($countones(res[7:0]) % 2 == 0);
                fo[7] = 0; fo[11] = 0;
            end
            4'd5: fo[10] = 0;
            4'd7: fo[10] = 1;
            4'd9, 4'd10, 4'd11: begin
                n = int'(b[4:0]);
                if (n == 0) res = 32'(ua);
                else begin
                    if (op == 4'd9) begin
                        res = 32'((ua << n) & mask);
                        fo[0] = (n <= w) ? ((ua >> (w - n)) & 1) != 0 : 1'b0;
                        fo[11] = (n == 1) && (res[w-1] != fo[0]);
                    end else if (op == 4'd10) begin
                        res = 32'(ua >> n);
                        fo[0] = (n <= w) ? ((ua >> (n - 1)) & 1) != 0 : 1'b0;
                        fo[11] = (n == 1) && (sa < 0);
                    end else begin
                        res = 32'((sa >>> n) & mask);
                        fo[0] = (n <= w) ? ((ua >> (n - 1)) & 1) != 0 : (sa < 0);
                        fo[11] = 0;
                    end
                    fo[4] = 0;
                    szp = 1;
                end
            end
            default: res = 0;
        endcase
        if (szp) begin
            fo[7] = res[w-1];
            fo[6] = (res == 0);
            fo[2] = ($countones(res[7:0]) % 2 == 0);
        end
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding model result.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus32.out_valid) begin
            if (q32.size() == 0) chk("unexpected_out32", 32'd1, 32'd0);
            else begin
                chk("result32", bus32.result, q32[0][63:32]);
                chk("flags32", bus32.flags_out, q32[0][31:0]);
                if (bus32.out_ready) void'(q32.pop_front());
            end
        end
        if (reset === 1'b1 && bus8.out_valid) begin
            if (q8.size() == 0) chk("unexpected_out8", 32'd1, 32'd0);
            else begin
                chk("result8", {24'd0, bus8.result}, q8[0][63:32]);
                chk("flags8", bus8.flags_out, q8[0][31:0]);
                if (bus8.out_ready) void'(q8.pop_front());
            end
        end
    end

    task automatic drive32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] f);
        logic [31:0] r, fo;
        bus32.op = op; bus32.a = a; bus32.b = b; bus32.flags_in = f; bus32.in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus32.in_ready) break;
        end
        if (!bus32.in_ready) chk("accept_timeout32", 32'd0, 32'd1);
        model(32, op, a, b, f, r, fo);
        q32.push_back({r, fo});
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] f);
        @(posedge clk); #1;
        drive32(op, a, b, f);
    endtask

    task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [31:0] f);
        logic [31:0] r, fo;
        @(posedge clk); #1;
        bus8.op = op; bus8.a = a; bus8.b = b; bus8.flags_in = f; bus8.in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus8.in_ready) break;
        end
        if (!bus8.in_ready) chk("accept_timeout8", 32'd0, 32'd1);
        model(8, op, {24'd0, a}, {24'd0, b}, f, r, fo);
        q8.push_back({r, fo});
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    // Waits for out_valid on the 32-bit instance, counting cycles, busy cycles and busy-while-ready.
    task automatic wait32(output int cyc, output int bsy, output int bad);
        cyc = 0; bsy = 0; bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus32.busy) begin
                bsy++;
                if (bus32.in_ready) bad++;
            end
        end while (!bus32.out_valid && cyc < 60);
        if (!bus32.out_valid) chk("out_timeout32", 32'd0, 32'd1);
    endtask

    int cyc, bsy, bad, seen;

    initial begin
        reset = 1'b0;
        bus32.in_valid = 0; bus32.op = 0; bus32.a = 0; bus32.b = 0; bus32.flags_in = 0; bus32.out_ready = 1;
        bus8.in_valid  = 0; bus8.op  = 0; bus8.a  = 0; bus8.b  = 0; bus8.flags_in  = 0; bus8.out_ready  = 1;
        #1;
        chk("rst_out_valid", {31'd0, bus32.out_valid}, 32'd0);
        chk("rst_result", bus32.result, 32'd0);
        chk("rst_flags", bus32.flags_out, 32'd0);
        chk("rst_busy", {31'd0, bus32.busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        send32(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
        wait32(cyc, bsy, bad);
        chk("add_latency", cyc, 32'd1);
        chk("add_result", bus32.result, 32'h8000_0000);
        chk("add_flags", bus32.flags_out, 32'h0000_0894);

        send32(4'd6, 32'd1, 32'd2, 32'd0);
        wait32(cyc, bsy, bad);
        chk("cmp_result", bus32.result, 32'hFFFF_FFFF);
        chk("cmp_flags", bus32.flags_out, 32'h0000_0095);

        send32(4'd3, 32'h9A, 32'd0, 32'd0);
        wait32(cyc, bsy, bad);
        chk("daa9a_result", bus32.result, 32'd0);
        chk("daa9a_flags", bus32.flags_out, 32'h0000_0055);
        send32(4'd3, 32'h45, 32'd0, 32'd0);
        wait32(cyc, bsy, bad);
        chk("daa45_result", bus32.result, 32'h45);
        chk("daa45_cf", {31'd0, bus32.flags_out[0]}, 32'd0);

        send32(4'd9, 32'h2000_0001, 32'd3, 32'd0);
        wait32(cyc, bsy, bad);
        chk("shl_latency", cyc, 32'd4);
        chk("shl_busy_cycles", bsy, 32'd3);
        chk("shl_ready_while_busy", bad, 32'd0);
        chk("shl_result", bus32.result, 32'h0000_0008);
        chk("shl_flags", bus32.flags_out, 32'h0000_0001);

        send32(4'd9, 32'h0000_1234, 32'd0, 32'h0000_08C5);
        wait32(cyc, bsy, bad);
        chk("shl0_latency", cyc, 32'd1);
        chk("shl0_result", bus32.result, 32'h0000_1234);
        chk("shl0_flags", bus32.flags_out, 32'h0000_08C5);

        send32(4'd7, 32'h1234_5678, 32'd9, 32'd0);
        wait32(cyc, bsy, bad);
        chk("std_flags", bus32.flags_out, 32'h0000_0400);
        send32(4'd2, 32'h0F0F_0F0F, 32'd0, 32'h0000_08C5);
        wait32(cyc, bsy, bad);
        chk("not_result", bus32.result, 32'hF0F0_F0F0);
        chk("not_flags", bus32.flags_out, 32'h0000_08C5);

        // Further patterns checked only against the model.
        send32(4'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF);
        send32(4'd8, 32'h7FFF_FFFF, 32'd0, 32'h0000_0001);
        send32(4'd1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        send32(4'd4, 32'hF0F0_00FF, 32'h8F00_0003, 32'h0000_0811);
        send32(4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF);
        send32(4'd6, 32'h8000_0000, 32'd1, 32'd0);
        send32(4'd9, 32'hC000_0000, 32'd1, 32'd0);
        send32(4'd10, 32'h8000_0001, 32'd1, 32'd0);
        send32(4'd11, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF);
        send32(4'd11, 32'h8765_4321, 32'd31, 32'd0);
        send32(4'd13, 32'h1111_1111, 32'd2, 32'h0000_0A5A);
        send32(4'd3, 32'hFF, 32'd0, 32'd0);
        wait32(cyc, bsy, bad);

        // Backpressure: result must hold while the consumer stalls.
        @(posedge clk); #1 bus32.out_ready = 1'b0;
        send32(4'd0, 32'd5, 32'd6, 32'd0);
        wait32(cyc, bsy, bad);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, bus32.in_ready}, 32'd0);
            chk("bp_hold", bus32.result, 32'd11);
        end
        @(posedge clk); #1 bus32.out_ready = 1'b1;
        drive32(4'd0, 32'd1, 32'd2, 32'd0);
        @(negedge clk);
        chk("bp_next_valid", {31'd0, bus32.out_valid}, 32'd1);
        chk("bp_next_result", bus32.result, 32'd3);

        send32(4'd10, 32'h8000_0001, 32'd3, 32'd0);
        bus32.out_ready = 1'b0;
        wait32(cyc, bsy, bad);
        chk("shr_bp_latency", cyc, 32'd4);
        repeat (3) @(negedge clk);
        chk("shr_bp_hold", bus32.result, 32'h1000_0000);
        chk("shr_bp_flags", bus32.flags_out, 32'h0000_0004);
        @(posedge clk); #1 bus32.out_ready = 1'b1;

        send8(4'd8, 8'hFF, 8'h00, 32'h0000_0001);
        cyc = 0;
        while (!bus8.out_valid && cyc < 60) begin @(negedge clk); cyc++; end
        chk("adc8_result", {24'd0, bus8.result}, 32'd0);
        chk("adc8_flags", bus8.flags_out, 32'h0000_0055);
        send8(4'd10, 8'hA5, 8'd10, 32'd0);
        send8(4'd9, 8'h81, 8'd8, 32'd0);
        send8(4'd11, 8'h80, 8'd12, 32'd0);
        send8(4'd0, 8'h80, 8'h80, 32'd0);
        repeat (40) @(negedge clk);
        chk("q8_drained", q8.size(), 32'd0);
        chk("q32_drained", q32.size(), 32'd0);

        // Reset mid-shift must abort with no result afterwards.
        send32(4'd10, 32'hFFFF_0000, 32'd20, 32'd0);
        repeat (5) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, bus32.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus32.busy}, 32'd0);
        q32.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus32.out_valid) seen++;
        end
        chk("abort_no_output", seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
